wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Round-robin arbiter that shares the single write-back port among NREQ execution-stage producers (bypass, ALU, MDU, LSU, ...).
- Each producer presents a valid/itag pair with a ready return.
- The arbiter grants one producer per cycle into a registered output stage driving the write-back master.
- Sits between the exe-stage units and the write-back/commit logic; obeys pipeline flush.

Parameters:
NREQ, 4, number of requesting producers (2..8)
TAGW, 8, instruction tag width
SRCW, 2, width of source index; must equal clog2(NREQ) (min 1)
CNTW, 16, width of each stall counter (optional feature only)

Ports:
clk_i  input  1  clock, all logic on rising edge
arst_i  input  1  reset, synchronous, active-high
flush_i  input  1  pipeline flush, synchronous, active-high
req_valid_i  input  NREQ  per-producer valid
req_itag_i  input  NREQ*TAGW  per-producer itag; slice i = bits [i*TAGW +: TAGW]
req_ready_o  output  NREQ  per-producer accept (one-hot or zero)
wb_valid_o  output  1  write-back valid (registered)
wb_itag_o  output  TAGW  write-back itag (registered)
wb_src_o  output  SRCW  index of the producer whose itag is in wb_itag_o (registered)
wb_ready_i  input  1  write-back consumer ready
stall_cnt_o  output  NREQ*CNTW  per-producer stall counters (present only with the optional feature)

Behaviour:
- Clock and reset: one clock, clk_i. arst_i is synchronous and active-high. It is sampled only at the rising edge of clk_i; it has no asynchronous effect.
- Reset values: wb_valid_o=0, rr_ptr=0, stall counters=0. wb_itag_o and wb_src_o are don't-care while wb_valid_o=0, but the RTL resets them to 0.
- Load enable: load_en = !wb_valid_o | wb_ready_i. The output stage is empty, or is being drained this cycle.
- Grant (combinational):
  - When load_en=1, flush_i=0 and arst_i=0, grant = first set bit of req_valid_i, searching circularly from index rr_ptr upward with wrap at NREQ-1 -> 0.
  - Otherwise grant=0.
  - req_ready_o = grant. It is never asserted for a producer whose req_valid_i=0.
  - Producers must hold valid/itag stable until ready; the arbiter does not register requests.
- Output register update, in priority order:
  - arst_i or flush_i: wb_valid_o <= 0.
  - load_en: wb_valid_o <= |grant, wb_itag_o <= itag of granted producer, wb_src_o <= granted index.
  - else: hold all output registers.
- Latency: 1 cycle from accept (req_valid & req_ready) to wb_valid_o.
- Throughput: with wb_ready_i held at 1, one item per cycle.
- Pointer:
  - On any grant to index k, rr_ptr <= (k+1) mod NREQ. This handles NREQ that is not a power of two.
  - No grant: rr_ptr holds.
  - Flush: rr_ptr holds. Reset: rr_ptr <= 0.
- Fairness: a continuously valid producer is granted within NREQ grants.
- Backpressure: wb_valid_o=1 & wb_ready_i=0 -> load_en=0, no grants, outputs hold (itag and src stable).
- Simultaneous drain and load: wb_valid_o=1 & wb_ready_i=1 with a requester valid -> new item loaded in the same edge; no bubble.
- Flush with output valid and ready high: the item is considered consumed by the consumer, but no new item is loaded that cycle.
- Flush mid-stall: output cleared; a stalled producer is re-arbitrated from the next cycle if it still asserts valid.
- No combinational path from wb_ready_i to wb_valid_o. There is a combinational path from wb_ready_i to req_ready_o, which is intended.

Optional Feature:
- Macro: WB_ARBITER_STALL_CNT_EN.
- Defined:
  - stall_cnt_o exists.
  - Counter i increments (saturating at all-ones) each cycle req_valid_i[i]=1 & req_ready_o[i]=0 & flush_i=0.
  - Counters clear on arst_i only; flush_i does not clear them.
- Not defined: port, counters and related logic are absent; no other behaviour changes.

Test Plan:
1. Reset then idle: arst_i=1 for 2 cycles, all req_valid_i=0 -> wb_valid_o=0, req_ready_o=0, rr_ptr=0 after release.
2. All 4 producers valid with itags 0x10,0x11,0x12,0x13, wb_ready_i=1 for 8 cycles -> wb_itag_o sequence 0x10,0x11,0x12,0x13,0x10,... starting 1 cycle after the first grant, and wb_src_o 0,1,2,3,0,...
3. Producer 2 valid (itag 0xA5), wb_ready_i=0 for 3 cycles after it is loaded, producer 0 also valid -> wb_itag_o holds 0xA5, req_ready_o=0 throughout. When wb_ready_i rises, producer 0 is granted the same cycle and wb_itag_o is its itag on the next edge.
4. Output valid, wb_ready_i=1, flush_i=1 with producers 1 and 3 valid -> req_ready_o=0, wb_valid_o=0 next cycle. The following cycle grants start from the unchanged rr_ptr.
5. NREQ=3, producers 0 and 2 continuously valid -> grants alternate 0,2,0,2; pointer wraps 2->0 correctly; no grant ever to idle producer 1.
6. With WB_ARBITER_STALL_CNT_EN: producer 1 valid, wb_ready_i=0 for 5 cycles with output occupied -> stall_cnt for producer 1 = 5. Hold until 2^CNTW cycles -> counter saturates at all-ones. arst_i -> 0.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter that shares the single write-back port
// among NREQ execution-stage producers. One producer is granted per cycle
// into a registered output stage that drives the write-back consumer.
//
// Optional feature: define WB_ARBITER_STALL_CNT_EN to add per-producer
// saturating stall counters (parameter CNTW, port stall_cnt_o).
//
// Reset (arst_i) is synchronous and active-high. flush_i empties the output
// stage without moving the round-robin pointer.

module wb_arbiter #(
    parameter int NREQ = 4,
    parameter int TAGW = 8,
    parameter int SRCW = 2
`ifdef WB_ARBITER_STALL_CNT_EN
    ,
    parameter int CNTW = 16
`endif
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 flush_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*TAGW-1:0] req_itag_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 wb_valid_o,
    output logic [TAGW-1:0]      wb_itag_o,
    output logic [SRCW-1:0]      wb_src_o,
    input  logic                 wb_ready_i
`ifdef WB_ARBITER_STALL_CNT_EN
    ,
    output logic [NREQ*CNTW-1:0] stall_cnt_o
`endif
);

    // Output stage and round-robin pointer.
    logic            wb_valid_q, wb_valid_d;
    logic [TAGW-1:0] wb_itag_q,  wb_itag_d;
    logic [SRCW-1:0] wb_src_q,   wb_src_d;
    logic [SRCW-1:0] rr_ptr_q,   rr_ptr_d;

    // Arbitration results for the current cycle.
    logic            load_en;
    logic [NREQ-1:0] grant;
    logic            any_grant;
    logic [SRCW-1:0] grant_idx;
    logic [TAGW-1:0] grant_itag;

    // The output stage can accept a new item when it is empty or is being
    // drained this cycle; this is the only path from wb_ready_i to req_ready_o.
    assign load_en   = !wb_valid_q || wb_ready_i;
    assign any_grant = |grant;

    // Circular priority search for the first valid producer at or after rr_ptr.
    always_comb begin
        int   pos;
        logic found;
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant = '0;
        pos   = 0;
        found = 1'b0;
        if (load_en && !flush_i && !arst_i) begin
            for (int off = 0; off < NREQ; off++) begin
                pos = int'(rr_ptr_q) + off;
                if (pos >= NREQ) begin
                    pos = pos - NREQ;
                end
                if (!found && req_valid_i[SRCW'(pos)]) begin
                    found                = 1'b1;
                    grant[SRCW'(pos)]    = 1'b1;
                end
            end
        end
    end

    // Encode the one-hot grant into an index and select that producer's itag.
    always_comb begin
        grant_idx  = '0;
        grant_itag = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx  = SRCW'(i);
                grant_itag = req_itag_i[i*TAGW +: TAGW];
            end
        end
    end

    // Next-state for the output stage and the round-robin pointer.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_itag_d  = wb_itag_q;
        wb_src_d   = wb_src_q;
        rr_ptr_d   = rr_ptr_q;

        if (flush_i) begin
            // The item on the output (if any) is dropped or, with wb_ready_i
            // high, treated as consumed; nothing new loads this cycle.
            wb_valid_d = 1'b0;
        end else if (load_en) begin
            wb_valid_d = any_grant;
            wb_itag_d  = grant_itag;
            wb_src_d   = grant_idx;
        end

        // Advance past the winner; explicit wrap handles NREQ that is not a
        // power of two. grant is already zero under flush, so the pointer holds.
        if (any_grant) begin
            if (int'(grant_idx) == NREQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + SRCW'(1);
            end
        end
    end

    // Register the output stage and pointer; reset wins over everything.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (arst_i) begin
            wb_valid_q <= 1'b0;
            wb_itag_q  <= '0;
            wb_src_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_itag_q  <= wb_itag_d;
            wb_src_q   <= wb_src_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign req_ready_o = grant;
    assign wb_valid_o  = wb_valid_q;
    assign wb_itag_o   = wb_itag_q;
    assign wb_src_o    = wb_src_q;

`ifdef WB_ARBITER_STALL_CNT_EN
    logic [NREQ-1:0][CNTW-1:0] stall_cnt_q, stall_cnt_d;

    // A producer stalls when it is valid but not accepted; flush cycles are
    // not counted, and counters saturate at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid_i[i] && !grant[i] && !flush_i &&
                stall_cnt_q[i] != {CNTW{1'b1}}) begin
                stall_cnt_d[i] = stall_cnt_q[i] + CNTW'(1);
            end
        end
    end

    // Stall counters clear only on reset; flush leaves them intact.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    // No stall counters in this build; the arbitration path is unchanged.
`endif

endmodule
